// File: rtl/bht_update_queue_pkg.sv
// Shared configuration and branch-update types, plus local types for the
// BHT update queue.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

package ariane_pkg;

    localparam int unsigned VLEN = 64;
    localparam int unsigned BHT_UPDATE_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

package bht_update_queue_pkg;

    typedef struct packed {
        logic [ariane_pkg::VLEN-1:0] pc;
        logic                        taken;
    } bhtq_entry_t;

    // What happens to this cycle's resolution.
    typedef enum logic [1:0] {
        Q_IDLE,
        Q_PUSH,
        Q_COALESCE,
        Q_DROP
    } q_action_e;

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bht_update_queue_if.sv
// Bundle of the signals between the branch unit, the update queue and the BHT.
interface bht_update_queue_if;

    ariane_pkg::bht_update_t resolved;
    ariane_pkg::bht_update_t bht_update;
    logic                    hold;
    logic                    full;
    logic                    empty;
    logic [7:0]              drop_cnt;

    modport master (
        output resolved, hold,
        input  bht_update, full, empty, drop_cnt
    );

    modport slave (
        input  resolved, hold,
        output bht_update, full, empty, drop_cnt
    );

endinterface

// File: rtl/bht_update_queue.sv
// Circular buffer of resolved branches, drained one entry per cycle into the
// BHT; same-pc back-to-back resolutions coalesce into the newest entry.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = ariane_pkg::BHT_UPDATE_QUEUE_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    debug_mode_i,
    input  ariane_pkg::bht_update_t resolved_i,
    output ariane_pkg::bht_update_t bht_update_o,
    input  logic                    hold_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [7:0]              drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("bht_update_queue: DEPTH must be a power of two >= 2");
    end
    if (CVA6Cfg.VLEN > ariane_pkg::VLEN) begin : g_bad_vlen
        $error("bht_update_queue: configured VLEN exceeds bht_update_t pc width");
    end

    bhtq_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q, newest_ptr;
    logic [CNT_W-1:0]        count_q, count_next;
    logic                    full_q, empty_q;
    logic [7:0]              drop_cnt_q;
    logic                    push_req, pop, coalesce;
    q_action_e               action;

    assign push_req   = resolved_i.valid & ~debug_mode_i & ~flush_i;
    assign pop        = ~empty_q & ~hold_i & ~debug_mode_i & ~flush_i;
    assign newest_ptr = wr_ptr_q - PTR_W'(1);

    // A single entry that is leaving this cycle is no longer a coalesce target.
    assign coalesce = push_req & ~empty_q
                    & (mem_q[newest_ptr].pc == resolved_i.pc)
                    & ~(pop & (count_q == CNT_W'(1)));

    always_comb begin
        action = Q_IDLE;
        if (push_req) begin
            if (coalesce)            action = Q_COALESCE;
            else if (!full_q || pop) action = Q_PUSH;
            else                     action = Q_DROP;
        end
    end

    always_comb begin
        count_next = count_q;
        if (action == Q_PUSH) count_next = count_next + CNT_W'(1);
        if (pop)              count_next = count_next - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            drop_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case (action)
                Q_PUSH: begin
                    mem_q[wr_ptr_q] <= '{pc: resolved_i.pc, taken: resolved_i.taken};
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                Q_COALESCE: mem_q[newest_ptr].taken <= resolved_i.taken;
                Q_DROP:     if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 8'd1;
                default: ;
            endcase
            count_q <= count_next;
            full_q  <= (count_next == FULL_CNT);
            empty_q <= (count_next == '0);
        end
    end

    always_comb begin
        bht_update_o = '0;
        if (pop) begin
            bht_update_o.valid = 1'b1;
            bht_update_o.pc    = mem_q[rd_ptr_q].pc;
            bht_update_o.taken = mem_q[rd_ptr_q].taken;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed scoreboard bench for bht_update_queue (DEPTH = 4).
module tb_bht_update_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    logic dbg = 1'b0;

    bht_update_queue_if bus ();

    bht_update_queue #(
        .CVA6Cfg (config_pkg::cva6_cfg_empty),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush),
        .debug_mode_i (dbg),
        .resolved_i   (bus.resolved),
        .bht_update_o (bus.bht_update),
        .hold_i       (bus.hold),
        .full_o       (bus.full),
        .empty_o      (bus.empty),
        .drop_cnt_o   (bus.drop_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   drops    = 0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".empty"}, 66'(bus.empty), 66'(sb.size() == 0));
        chk({tag, ".full"}, 66'(bus.full), 66'(sb.size() == DEPTH));
        chk({tag, ".drop"}, 66'(bus.drop_cnt), 66'(drops));
    endtask

    // One clock cycle: drive at negedge, check the output before the edge,
    // advance the model, then check registered status after the edge.
    task automatic step(input string tag, input logic v, input logic [63:0] pc,
                        input logic t, input logic h, input logic d, input logic f);
        logic        pop, push_req, coal;
        logic [65:0] exp_out;
        bus.resolved = '{valid: v, pc: pc, taken: t};
        bus.hold     = h;
        dbg          = d;
        flush        = f;
        #1;
        pop     = (sb.size() != 0) && !h && !d && !f;
        exp_out = pop ? {1'b1, sb[0].pc, sb[0].taken} : '0;
        chk({tag, ".out"}, bus.bht_update, exp_out);

        push_req = v && !d && !f;
        if (f) begin
            sb.delete();
        end else begin
            coal = push_req && (sb.size() != 0) && (sb[sb.size()-1].pc == pc)
                   && !(pop && sb.size() == 1);
            if (pop) void'(sb.pop_front());
            if (coal) sb[sb.size()-1].taken = t;
            else if (push_req) begin
                if (sb.size() < DEPTH) sb.push_back('{pc: pc, taken: t});
                else if (drops < 255) drops++;
            end
        end
        @(posedge clk);
        #1;
        chk_status(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.resolved = '0;
        bus.hold     = 1'b0;
        #12;
        chk("reset.out", bus.bht_update, '0);
        chk_status("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // Single push appears next cycle, queue empty after that.
        step("s1.push", 1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("s1.out");
        idle("s1.after");

        // Fill under hold, fifth distinct pc dropped, then in-order drain.
        for (int i = 0; i < 5; i++)
            step("s2.fill", 1'b1, 64'h1000 + 64'(i) * 64'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle("s2.drain");

        // Full queue, push coinciding with a pop is accepted.
        for (int i = 0; i < 4; i++)
            step("s3.fill", 1'b1, 64'h2000 + 64'(i) * 64'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        step("s3.pushpop", 1'b1, 64'h2100, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle("s3.drain");

        // Back-to-back same pc coalesces into one entry with the later outcome.
        step("s4.a", 1'b1, 64'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s4.b", 1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("s4.drain");
        idle("s4.after");

        // Same pc while the sole entry is popped must push, not coalesce.
        step("s7.a", 1'b1, 64'h300, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s7.b", 1'b1, 64'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("s7.drain");
        idle("s7.after");

        // Flush with a valid resolution: empty, no output, no drop.
        for (int i = 0; i < 3; i++)
            step("s5.fill", 1'b1, 64'h4000 + 64'(i) * 64'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s5.flush", 1'b1, 64'h4100, 1'b1, 1'b0, 1'b0, 1'b1);
        idle("s5.after");

        // Debug mode freezes the queue; drain resumes afterwards.
        step("s6.a", 1'b1, 64'h5000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("s6.b", 1'b1, 64'h5010, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("s6.dbg", 1'b1, 64'h6000 + 64'(i) * 64'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        idle("s6.drain");

        // Asynchronous reset mid-drain.
        #2;
        rst_ni = 1'b0;
        #1;
        sb.delete();
        drops = 0;
        chk("s6.rst.out", bus.bht_update, '0);
        chk_status("s6.rst");
        @(negedge clk);
        rst_ni = 1'b1;
        idle("s6.post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
